// File: rtl/alu_mdu_unit.sv
// Execute-stage unit: base RV32I ALU with single-cycle latency plus an optional
// RV32M path (fixed-latency multiply, iterative radix-2 restoring divide).
module alu_mdu_unit #(
    parameter int XLEN    = 32,
    parameter int MEXT    = 1,
    parameter int MUL_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOp,
    input  logic [5:0]      funct,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    // state   | meaning
    // IDLE    | accepting ops; base ops and divide fast paths complete from here
    // MUL     | multiply product held, waiting out the remaining latency
    // DIV     | restoring divide, one quotient bit per cycle
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;

    localparam int SHW      = $clog2(XLEN);
    localparam int CNT_MAX  = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
    localparam int CW       = $clog2(CNT_MAX + 1);
    localparam int MUL_CNT0 = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;

    state_t          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            out_valid_q, out_valid_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] hold_q, hold_d;
    logic [XLEN-1:0] dq_q, dq_d;
    logic [XLEN-1:0] dr_q, dr_d;
    logic [XLEN-1:0] dd_q, dd_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic            is_rem_q, is_rem_d;

    logic            accept;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] base_res;

    assign in_ready = (state_q == ST_IDLE) & ~flush & ~rst;
    assign accept   = in_valid & in_ready;
    assign shamt    = src_b[SHW-1:0];

    always_comb begin
        base_res = '0;
        unique case (ALUOp)
            2'd0: base_res = src_a + src_b;
            2'd1: base_res = src_a - src_b;
            2'd3: base_res = src_b << 12;
            default: begin
                unique case (funct[2:0])
                    3'd0: begin
                        if (funct[5] & funct[1]) base_res = src_a - src_b;
                        else                     base_res = src_a + src_b;
                    end
                    3'd1: base_res = src_a << shamt;
                    3'd2: base_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
                    3'd3: base_res = {{(XLEN-1){1'b0}}, src_a < src_b};
                    3'd4: base_res = src_a ^ src_b;
                    3'd5: begin
                        if (funct[5]) base_res = $signed(src_a) >>> shamt;
                        else          base_res = src_a >> shamt;
                    end
                    3'd6: base_res = src_a | src_b;
                    default: base_res = src_a & src_b;
                endcase
            end
        endcase
    end

    logic              m_sel;
    logic              a_sgn, b_sgn;
    logic [2*XLEN-1:0] mul_a, mul_b, prod;
    logic [XLEN-1:0]   mul_res;

    assign m_sel = (MEXT != 0) && (ALUOp == 2'd2) && funct[4] && funct[1];
    assign a_sgn = (funct[1:0] == 2'b01) || (funct[1:0] == 2'b10);
    assign b_sgn = (funct[1:0] == 2'b01);

    // One unsigned 2*XLEN multiplier; signedness comes from operand extension.
    assign mul_a   = {{XLEN{src_a[XLEN-1] & a_sgn}}, src_a};
    assign mul_b   = {{XLEN{src_b[XLEN-1] & b_sgn}}, src_b};
    assign prod    = mul_a * mul_b;
    assign mul_res = (funct[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    logic            div_sgn, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b, fast_res;

    assign div_sgn  = ~funct[0];
    assign a_neg    = div_sgn & src_a[XLEN-1];
    assign b_neg    = div_sgn & src_b[XLEN-1];
    assign mag_a    = a_neg ? -src_a : src_a;
    assign mag_b    = b_neg ? -src_b : src_b;
    assign div_zero = (src_b == '0);
    assign div_ovf  = div_sgn && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
    always_comb begin
        fast_res = '0;
        if (div_zero) fast_res = funct[1] ? src_a : '1;
        else          fast_res = funct[1] ? '0 : src_a;
    end

    logic [XLEN:0]   r_shift, diff;
    logic [XLEN-1:0] q_nxt, r_nxt, div_res;

    always_comb begin
        r_shift = {dr_q, dq_q[XLEN-1]};
        diff    = r_shift - {1'b0, dd_q};
        if (!diff[XLEN]) begin
            r_nxt = diff[XLEN-1:0];
            q_nxt = {dq_q[XLEN-2:0], 1'b1};
        end else begin
            r_nxt = r_shift[XLEN-1:0];
            q_nxt = {dq_q[XLEN-2:0], 1'b0};
        end
        if (is_rem_q) div_res = r_neg_q ? -r_nxt : r_nxt;
        else          div_res = q_neg_q ? -q_nxt : q_nxt;
    end

    logic            load_en;
    logic [XLEN-1:0] load_val;

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = 1'b0;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        dq_d        = dq_q;
        dr_d        = dr_q;
        dd_d        = dd_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        is_rem_d    = is_rem_q;
        load_en     = 1'b0;
        load_val    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!m_sel) begin
                        load_en  = 1'b1;
                        load_val = base_res;
                    end else if (!funct[2]) begin
                        if (MUL_LAT == 1) begin
                            load_en  = 1'b1;
                            load_val = mul_res;
                        end else begin
                            hold_d  = mul_res;
                            cnt_d   = CW'(MUL_CNT0);
                            state_d = ST_MUL;
                        end
                    end else if (div_zero || div_ovf) begin
                        load_en  = 1'b1;
                        load_val = fast_res;
                    end else begin
                        dq_d     = mag_a;
                        dd_d     = mag_b;
                        dr_d     = '0;
                        q_neg_d  = a_neg ^ b_neg;
                        r_neg_d  = a_neg;
                        is_rem_d = funct[1];
                        cnt_d    = CW'(XLEN - 1);
                        state_d  = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    load_en  = 1'b1;
                    load_val = hold_q;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DIV: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    dq_d = q_nxt;
                    dr_d = r_nxt;
                    if (cnt_q == '0) begin
                        load_en  = 1'b1;
                        load_val = div_res;
                        state_d  = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_en) begin
            out_valid_d = 1'b1;
            result_d    = load_val;
            zero_d      = (load_val == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            hold_q      <= '0;
            dq_q        <= '0;
            dr_q        <= '0;
            dd_q        <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            is_rem_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            dq_q        <= dq_d;
            dr_q        <= dr_d;
            dd_q        <= dd_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            is_rem_q    <= is_rem_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_mdu_unit.sv
// Bench for alu_mdu_unit: directed and randomized ops against an arithmetic
// reference model; a second instance with MEXT=0 covers the base-only decode.
module tb_alu_mdu_unit;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid;
    logic [1:0]  ALUOp;
    logic [5:0]  funct;
    logic [31:0] src_a, src_b;
    logic        rdy_a, ov_a, zero_a, busy_a;
    logic [31:0] res_a;
    logic        rdy_b, ov_b, zero_b, busy_b;
    logic [31:0] res_b;

    int          total = 0;
    int          passed = 0;
    int          fails = 0;
    logic [31:0] last_res;

    always #5 clk = ~clk;

    alu_mdu_unit #(.XLEN(XLEN), .MEXT(1), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
        .ALUOp(ALUOp), .funct(funct), .src_a(src_a), .src_b(src_b),
        .out_valid(ov_a), .result(res_a), .zero(zero_a), .busy(busy_a));

    alu_mdu_unit #(.XLEN(XLEN), .MEXT(0), .MUL_LAT(MUL_LAT)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
        .ALUOp(ALUOp), .funct(funct), .src_a(src_a), .src_b(src_b),
        .out_valid(ov_b), .result(res_b), .zero(zero_b), .busy(busy_b));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: result and cycles from accept to out_valid.
    function automatic void model(input logic [1:0] op, input logic [5:0] f,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input bit mext, output logic [31:0] r, output int lat);
        logic signed [63:0] sa, sb, p;
        logic [63:0]        ua, ub, pu;
        logic [31:0]        q, rm;
        bit                 sgn;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        lat = 1;
        r   = '0;
        if (mext && op == 2'd2 && f[4] && f[1]) begin
            case (f[2:0])
                3'd0: begin pu = ua * ub;          r = pu[31:0];  lat = MUL_LAT; end
                3'd1: begin p  = sa * sb;          r = p[63:32];  lat = MUL_LAT; end
                3'd2: begin p  = sa * $signed(ub); r = p[63:32];  lat = MUL_LAT; end
                3'd3: begin pu = ua * ub;          r = pu[63:32]; lat = MUL_LAT; end
                default: begin
                    sgn = !f[0];
                    if (b == 0) begin
                        q = 32'hFFFFFFFF; rm = a;
                    end else if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                        q = a; rm = 0;
                    end else begin
                        lat = XLEN + 1;
                        if (sgn) begin
                            q  = $signed(a) / $signed(b);
                            rm = $signed(a) % $signed(b);
                        end else begin
                            q  = a / b;
                            rm = a % b;
                        end
                    end
                    r = f[1] ? rm : q;
                end
            endcase
        end else begin
            case (op)
                2'd0: r = a + b;
                2'd1: r = a - b;
                2'd3: r = b << 12;
                default: begin
                    case (f[2:0])
                        3'd0: r = (f[5] && f[1]) ? a - b : a + b;
                        3'd1: r = a << b[4:0];
                        3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        3'd3: r = (a < b) ? 32'd1 : 32'd0;
                        3'd4: r = a ^ b;
                        3'd5: begin
                            if (f[5]) r = $signed(a) >>> b[4:0];
                            else      r = a >> b[4:0];
                        end
                        3'd6: r = a | b;
                        default: r = a & b;
                    endcase
                end
            endcase
        end
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b, input bit sel);
        logic [31:0] er;
        int          el, cyc, bc, rc;
        bit          got;
        model(op, f, a, b, !sel, er, el);
        ALUOp = op; funct = f; src_a = a; src_b = b; in_valid = 1'b1;
        #1;
        check({tag, "_ready"}, {31'b0, sel ? rdy_b : rdy_a}, 32'd1);
        step();
        in_valid = 1'b0;
        ALUOp = 2'($urandom); funct = 6'($urandom); src_a = $urandom; src_b = $urandom;
        cyc = 1; bc = 0; rc = 0; got = 1'b0;
        while (!got && cyc <= 60) begin
            if ((sel ? ov_b : ov_a) === 1'b1) begin
                got = 1'b1;
            end else begin
                if ((sel ? busy_b : busy_a) === 1'b1) bc++;
                if ((sel ? rdy_b : rdy_a) !== 1'b0) rc++;
                step();
                cyc++;
            end
        end
        check({tag, "_lat"}, got ? cyc : 0, el);
        check({tag, "_res"}, sel ? res_b : res_a, er);
        check({tag, "_zero"}, {31'b0, sel ? zero_b : zero_a}, {31'b0, er == 0});
        check({tag, "_busy"}, bc, el - 1);
        check({tag, "_rdy_busy"}, rc, 0);
        step();
        check({tag, "_pulse"}, {31'b0, sel ? ov_b : ov_a}, 32'd0);
        last_res = er;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] er, a, b;
        int          el, n;
        logic [1:0]  op;
        logic [5:0]  f;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        ALUOp = '0; funct = '0; src_a = '0; src_b = '0;
        repeat (2) step();
        check("rst_valid", {31'b0, ov_a}, 32'd0);
        check("rst_result", res_a, 32'd0);
        check("rst_zero", {31'b0, zero_a}, 32'd0);
        check("rst_busy", {31'b0, busy_a}, 32'd0);
        check("rst_ready", {31'b0, rdy_a}, 32'd0);
        in_valid = 1'b1;
        step();
        check("rst_dominates", {31'b0, ov_a}, 32'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("post_rst_ready", {31'b0, rdy_a}, 32'd1);

        run_op("sub", 2'd1, 6'b000000, 32'd5, 32'd7, 1'b0);
        run_op("rtype_f0", 2'd2, 6'b100000, 32'd5, 32'd7, 1'b0);
        run_op("lui", 2'd3, 6'b000000, $urandom, 32'h000ABCDE, 1'b0);
        run_op("sra", 2'd2, 6'b100101, 32'h80000000, 32'd4, 1'b0);
        a = $urandom;
        run_op("sub_zero", 2'd1, 6'($urandom), a, a, 1'b0);

        for (int i = 0; i < 12; i++)
            run_op("rand_any", 2'($urandom_range(0, 3)), 6'($urandom), $urandom, $urandom, 1'b0);

        op = 2'($urandom_range(0, 3)); f = 6'($urandom) & 6'b101111;
        a = $urandom; b = $urandom;
        model(op, f, a, b, 1'b1, er, el);
        ALUOp = op; funct = f; src_a = a; src_b = b; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("b2b_valid", {31'b0, ov_a}, 32'd1);
            check("b2b_res", res_a, er);
            if (i < 7) begin
                op = 2'($urandom_range(0, 3)); f = 6'($urandom) & 6'b101111;
                a = $urandom; b = $urandom;
                model(op, f, a, b, 1'b1, er, el);
                ALUOp = op; funct = f; src_a = a; src_b = b;
            end else begin
                in_valid = 1'b0;
            end
        end
        last_res = er;
        step();
        check("b2b_end", {31'b0, ov_a}, 32'd0);

        run_op("mulhsu", 2'd2, 6'b011010, 32'hFFFFFFFF, 32'd2, 1'b0);
        run_op("mulhu", 2'd2, 6'b011011, 32'hFFFFFFFF, 32'd2, 1'b0);
        run_op("rem", 2'd2, 6'b011110, 32'hFFFFFFF9, 32'd2, 1'b0);
        run_op("remu", 2'd2, 6'b011111, $urandom, $urandom_range(1, 1000), 1'b0);
        run_op("rem_div0", 2'd2, 6'b011110, 32'd9, 32'd0, 1'b0);
        run_op("remu_div0", 2'd2, 6'b011111, 32'd9, 32'd0, 1'b0);
        run_op("rem_ovf", 2'd2, 6'b011110, 32'h80000000, 32'hFFFFFFFF, 1'b0);

        for (int i = 0; i < 10; i++)
            run_op("rand_m", 2'd2, 6'($urandom) | 6'b010010, $urandom, $urandom, 1'b0);

        // Kill a divide mid-flight; the old result must stay put.
        ALUOp = 2'd2; funct = 6'b011110;
        src_a = $urandom; src_b = ($urandom & 32'h7FFFFFFF) | 32'd1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        check("flush_busy", {31'b0, busy_a}, 32'd0);
        check("flush_ready", {31'b0, rdy_a}, 32'd1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (ov_a !== 1'b0) n++;
            step();
        end
        check("flush_no_valid", n, 0);
        check("flush_hold", res_a, last_res);

        ALUOp = 2'd3; src_b = 32'd5; in_valid = 1'b1; flush = 1'b1;
        #1;
        check("flush_in_ready", {31'b0, rdy_a}, 32'd0);
        step();
        in_valid = 1'b0; flush = 1'b0;
        check("flush_in_valid", {31'b0, ov_a}, 32'd0);
        check("flush_in_hold", res_a, last_res);

        a = $urandom; b = $urandom;
        ALUOp = 2'd0; src_a = a; src_b = b; in_valid = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b1;
        #1;
        check("flush_at_valid", {31'b0, ov_a}, 32'd1);
        check("flush_at_res", res_a, a + b);
        step();
        flush = 1'b0;
        check("flush_at_end", {31'b0, ov_a}, 32'd0);

        run_op("pre_rst", 2'd3, 6'd0, 32'd0, 32'd1, 1'b0);
        ALUOp = 2'd2; funct = 6'b011011; src_a = $urandom; src_b = $urandom; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("mid_mul_busy", {31'b0, busy_a}, 32'd1);
        rst = 1'b1;
        step();
        check("mrst_valid", {31'b0, ov_a}, 32'd0);
        check("mrst_result", res_a, 32'd0);
        check("mrst_zero", {31'b0, zero_a}, 32'd0);
        check("mrst_busy", {31'b0, busy_a}, 32'd0);
        check("mrst_ready", {31'b0, rdy_a}, 32'd0);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (ov_a !== 1'b0) n++;
        end
        check("mrst_no_valid", n, 0);

        run_op("mext0", 2'd2, 6'b011110, 32'd3, 32'd4, 1'b1);
        n = 0;
        while (rdy_a !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("mext1_drain", {31'b0, rdy_a}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
